// File: rtl/adc_acq_seqgen.sv
// ADC acquisition sequencer: turns the ACQ_WND rising edge into a delayed,
// decimated capture window with sample strobes, completion pulses and counters.
module adc_acq_seqgen #(
    parameter int unsigned DLY_W  = 32,
    parameter int unsigned SPE_W  = 32,
    parameter int unsigned DEC_W  = 8,
    parameter int unsigned ECHO_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ACQ_WND,
    input  logic [DLY_W-1:0]  ADC_INIT_DELAY,
    input  logic [SPE_W-1:0]  SAMPLES_PER_ECHO,
    input  logic [DEC_W-1:0]  DECIM,
    input  logic              ABORT_ON_FALL,
    input  logic              CNT_CLR,
    output logic              ACQ_EN,
    output logic              SMP_STB,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORTED,
    output logic [ECHO_W-1:0] ECHO_CNT,
    output logic [ECHO_W-1:0] MISSED_CNT
);

    typedef enum logic [1:0] {IDLE, DELAY, ACQ, FIN} state_t;

    state_t             r_state, w_state_nx;
    logic               r_wnd_q;
    logic [DLY_W-1:0]   r_dly_cnt, w_dly_cnt_nx;
    logic [SPE_W-1:0]   r_spe, w_spe_nx, r_smp_cnt, w_smp_cnt_nx;
    logic [DEC_W-1:0]   r_dec, w_dec_nx, r_dec_cnt, w_dec_cnt_nx;
    logic               r_acq_en, w_acq_en_nx;
    logic               r_stb, w_stb_nx;
    logic               r_busy;
    logic               r_done, w_done_nx;
    logic               r_aborted, w_aborted_nx;
    logic [ECHO_W-1:0]  r_echo, r_missed;
    logic               w_trig, w_abort;

    assign w_trig  = ACQ_WND & ~r_wnd_q;
    assign w_abort = ABORT_ON_FALL & ~ACQ_WND;

    always_comb begin
        w_state_nx   = r_state;
        w_dly_cnt_nx = r_dly_cnt;
        w_spe_nx     = r_spe;
        w_dec_nx     = r_dec;
        w_smp_cnt_nx = r_smp_cnt;
        w_dec_cnt_nx = r_dec_cnt;
        w_acq_en_nx  = r_acq_en;
        w_stb_nx     = 1'b0;
        w_done_nx    = 1'b0;
        w_aborted_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_state_nx   = DELAY;
                    // Counters run down to zero, so load value-1 (a zero setting acts as 1)
                    w_dly_cnt_nx = (ADC_INIT_DELAY == '0) ? '0 : ADC_INIT_DELAY - DLY_W'(1);
                    w_spe_nx     = SAMPLES_PER_ECHO;
                    w_dec_nx     = (DECIM == '0) ? DEC_W'(1) : DECIM;
                end
            end
            DELAY: begin
                if (w_abort) begin
                    w_state_nx   = FIN;
                    w_aborted_nx = 1'b1;
                end else if (r_dly_cnt == '0) begin
                    if (r_spe == '0) begin
                        w_state_nx = FIN;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx   = ACQ;
                        w_acq_en_nx  = 1'b1;
                        w_stb_nx     = 1'b1;
                        w_smp_cnt_nx = r_spe - SPE_W'(1);
                        w_dec_cnt_nx = r_dec - DEC_W'(1);
                    end
                end else begin
                    w_dly_cnt_nx = r_dly_cnt - DLY_W'(1);
                end
            end
            ACQ: begin
                if (w_abort) begin
                    w_state_nx   = FIN;
                    w_acq_en_nx  = 1'b0;
                    w_aborted_nx = 1'b1;
                end else if (r_dec_cnt == '0) begin
                    if (r_smp_cnt == '0) begin
                        w_state_nx  = FIN;
                        w_acq_en_nx = 1'b0;
                        w_done_nx   = 1'b1;
                    end else begin
                        w_smp_cnt_nx = r_smp_cnt - SPE_W'(1);
                        w_dec_cnt_nx = r_dec - DEC_W'(1);
                        w_stb_nx     = 1'b1;
                    end
                end else begin
                    w_dec_cnt_nx = r_dec_cnt - DEC_W'(1);
                end
            end
            FIN: begin
                w_state_nx  = IDLE;
                w_acq_en_nx = 1'b0;
            end
            default: begin
                w_state_nx  = IDLE;
                w_acq_en_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_wnd_q   <= 1'b0;
            r_dly_cnt <= '0;
            r_spe     <= '0;
            r_dec     <= '0;
            r_smp_cnt <= '0;
            r_dec_cnt <= '0;
            r_acq_en  <= 1'b0;
            r_stb     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_wnd_q   <= ACQ_WND;
            r_dly_cnt <= w_dly_cnt_nx;
            r_spe     <= w_spe_nx;
            r_dec     <= w_dec_nx;
            r_smp_cnt <= w_smp_cnt_nx;
            r_dec_cnt <= w_dec_cnt_nx;
            r_acq_en  <= w_acq_en_nx;
            r_stb     <= w_stb_nx;
            r_busy    <= (w_state_nx != IDLE);
            r_done    <= w_done_nx;
            r_aborted <= w_aborted_nx;
        end
    end

    // Clear wins over any increment landing on the same edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_echo   <= '0;
            r_missed <= '0;
        end else if (CNT_CLR) begin
            r_echo   <= '0;
            r_missed <= '0;
        end else begin
            if (w_done_nx)
                r_echo <= r_echo + ECHO_W'(1);
            if (w_trig && (r_state != IDLE) && (r_missed != '1))
                r_missed <= r_missed + ECHO_W'(1);
        end
    end

    assign ACQ_EN     = r_acq_en;
    assign SMP_STB    = r_stb;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ABORTED    = r_aborted;
    assign ECHO_CNT   = r_echo;
    assign MISSED_CNT = r_missed;

endmodule

// File: tb/tb_adc_acq_seqgen.sv
// Directed bench for adc_acq_seqgen: a vector table of single windows plus
// hand-written sequences for missed triggers, counter clear and mid-window reset.
module tb_adc_acq_seqgen;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ACQ_WND = 1'b0;
    logic [31:0] ADC_INIT_DELAY = '0;
    logic [31:0] SAMPLES_PER_ECHO = '0;
    logic [7:0]  DECIM = '0;
    logic        ABORT_ON_FALL = 1'b0;
    logic        CNT_CLR = 1'b0;
    logic        ACQ_EN, SMP_STB, BUSY, DONE, ABORTED;
    logic [15:0] ECHO_CNT, MISSED_CNT;

    int checks = 0;
    int errors = 0;
    int exp_echo = 0;

    adc_acq_seqgen #(.DLY_W(32), .SPE_W(32), .DEC_W(8), .ECHO_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .ACQ_WND(ACQ_WND),
        .ADC_INIT_DELAY(ADC_INIT_DELAY), .SAMPLES_PER_ECHO(SAMPLES_PER_ECHO),
        .DECIM(DECIM), .ABORT_ON_FALL(ABORT_ON_FALL), .CNT_CLR(CNT_CLR),
        .ACQ_EN(ACQ_EN), .SMP_STB(SMP_STB), .BUSY(BUSY), .DONE(DONE),
        .ABORTED(ABORTED), .ECHO_CNT(ECHO_CNT), .MISSED_CNT(MISSED_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int d, n, m;
        bit aof;
        int l;
        int en_first, en_cnt, stb_cnt, stb_last, end_t;
        bit ab;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called at a negedge with ACQ_WND low for at least the previous edge
    task automatic run_vec(input int idx, input vec_t v);
        int en_first = -1, en_cnt = 0, stb_cnt = 0, stb_last = -1, end_t = -1;
        int n_done = 0, n_ab = 0, stray = 0;
        logic busy0 = 1'b0;
        ADC_INIT_DELAY   = v.d;
        SAMPLES_PER_ECHO = v.n;
        DECIM            = 8'(v.m);
        ABORT_ON_FALL    = v.aof;
        ACQ_WND          = 1'b1;
        for (int t = 0; t < 30; t++) begin
            cyc();
            if (t == 0) begin
                busy0 = BUSY;
                ADC_INIT_DELAY   = 77;
                SAMPLES_PER_ECHO = 99;
                DECIM            = 8'd5;
            end
            if (ACQ_EN) begin
                if (en_first < 0) en_first = t;
                en_cnt++;
            end
            if (SMP_STB) begin
                stb_cnt++;
                stb_last = t;
                if (!ACQ_EN) stray++;
            end
            if ((DONE || ABORTED) && end_t < 0) end_t = t;
            n_done += int'(DONE);
            n_ab   += int'(ABORTED);
            if (t == v.l - 1) ACQ_WND = 1'b0;
        end
        if (!v.ab) exp_echo++;
        chk($sformatf("v%0d_busy_at_trigger", idx), busy0, 1);
        chk($sformatf("v%0d_en_first", idx), en_first, v.en_first);
        chk($sformatf("v%0d_en_cycles", idx), en_cnt, v.en_cnt);
        chk($sformatf("v%0d_stb_count", idx), stb_cnt, v.stb_cnt);
        chk($sformatf("v%0d_stb_last", idx), stb_last, v.stb_last);
        chk($sformatf("v%0d_stb_outside_en", idx), stray, 0);
        chk($sformatf("v%0d_end_cycle", idx), end_t, v.end_t);
        chk($sformatf("v%0d_done_pulses", idx), n_done, v.ab ? 0 : 1);
        chk($sformatf("v%0d_abort_pulses", idx), n_ab, v.ab ? 1 : 0);
        chk($sformatf("v%0d_echo_cnt", idx), ECHO_CNT, exp_echo);
        chk($sformatf("v%0d_missed_cnt", idx), MISSED_CNT, 0);
        chk($sformatf("v%0d_idle_after", idx), BUSY, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        //            d  n   m aof  l  first cnt stb last end ab
        vecs[0] = '{3, 4,  1, 0, 20,  3,  4,  4,  6,  7, 0};
        vecs[1] = '{2, 3,  4, 0, 20,  2, 12,  3, 10, 14, 0};
        vecs[2] = '{2, 10, 1, 1,  5,  2,  3,  3,  4,  5, 1};
        vecs[3] = '{2, 10, 1, 0,  5,  2, 10, 10, 11, 12, 0};
        vecs[4] = '{0, 0,  5, 0,  3, -1,  0,  0, -1,  1, 0};
        vecs[5] = '{0, 2,  0, 0,  3,  1,  2,  2,  2,  3, 0};
        vecs[6] = '{1, 2,  3, 0,  3,  1,  6,  2,  4,  7, 0};
        vecs[7] = '{5, 2,  1, 1,  2, -1,  0,  0, -1,  2, 1};

        cyc();
        cyc();
        chk("reset_outputs", {ACQ_EN, SMP_STB, BUSY, DONE, ABORTED}, 0);
        chk("reset_counters", {ECHO_CNT, MISSED_CNT}, 0);
        RESET = 1'b0;
        cyc();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Re-trigger during ACQ counts as missed; clear lands on the DONE cycle
        ADC_INIT_DELAY = 2; SAMPLES_PER_ECHO = 3; DECIM = 8'd4; ABORT_ON_FALL = 1'b0;
        ACQ_WND = 1'b1;
        en_cnt = 0;
        for (int t = 0; t < 22; t++) begin
            cyc();
            en_cnt += int'(ACQ_EN);
            if (t == 3) ACQ_WND = 1'b0;
            if (t == 4) ACQ_WND = 1'b1;
            if (t == 6) chk("missed_after_retrigger", MISSED_CNT, 1);
            if (t == 14) begin
                chk("missed_done", DONE, 1);
                chk("missed_echo_before_clr", ECHO_CNT, exp_echo + 1);
                CNT_CLR = 1'b1;
            end
            if (t == 15) begin
                chk("clr_counters", {ECHO_CNT, MISSED_CNT}, 0);
                CNT_CLR = 1'b0;
                exp_echo = 0;
            end
        end
        chk("missed_no_restart_en", en_cnt, 12);
        chk("missed_idle_after", BUSY, 0);
        ACQ_WND = 1'b0;
        cyc();

        // Reset mid-window with ACQ_WND held high through release
        ADC_INIT_DELAY = 1; SAMPLES_PER_ECHO = 10; DECIM = 8'd1;
        ACQ_WND = 1'b1;
        for (int t = 0; t < 4; t++) cyc();
        chk("pre_reset_acq_en", ACQ_EN, 1);
        RESET = 1'b1;
        #1;
        chk("async_reset_outputs", {ACQ_EN, SMP_STB, BUSY, DONE, ABORTED}, 0);
        chk("async_reset_counters", {ECHO_CNT, MISSED_CNT}, 0);
        cyc();
        RESET = 1'b0;
        cyc();
        chk("retrigger_busy", BUSY, 1);
        cyc();
        chk("retrigger_acq_en", ACQ_EN, 1);
        ACQ_WND = 1'b0;
        for (int t = 0; t < 15; t++) cyc();
        chk("retrigger_echo", ECHO_CNT, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
